// File: rtl/spi_flash_cmd.sv
// SPI mode-0 command engine for serial NOR flash: opcode, optional address, then N read bytes.
// Latency: CLK_DIV setup + 2*CLK_DIV per bit + CLK_DIV hold + CLK_DIV deselect; start is ignored while busy.
module spi_flash_cmd #(
  parameter int CLK_DIV      = 2,
  parameter int ADDR_BYTES   = 3,
  parameter int MAX_RD_BYTES = 256,
  localparam int LW          = $clog2(MAX_RD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              cmd_op,
  input  logic                    has_addr,
  input  logic [8*ADDR_BYTES-1:0] addr,
  input  logic [LW-1:0]           rd_len,
  input  logic                    abort,
  input  logic                    spimiso,
  output logic                    spisck,
  output logic                    spimosi,
  output logic                    prom_cs_n,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int TW = 8 + AW;
  localparam int BW = $clog2(8 * MAX_RD_BYTES + TW + 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_RD_BYTES);
  localparam bit            DIV1     = (CLK_DIV == 1);

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DATA, HOLD, DESEL} state_t;

  state_t        state;
  logic [7:0]    div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] data_bits;
  logic [TW-2:0] tx_sr;
  logic [6:0]    rx_sr;
  logic          has_addr_q;
  logic          ab_pend;

  logic [LW-1:0] len_clamp;
  logic [BW-1:0] len_bits;
  logic          div_last;

  assign len_clamp = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
  assign len_bits  = BW'({len_clamp, 3'b000});
  assign div_last  = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      data_bits  <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      has_addr_q <= 1'b0;
      ab_pend    <= 1'b0;
      spisck     <= 1'b0;
      spimosi    <= 1'b0;
      prom_cs_n  <= 1'b1;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      // Once in DESEL the flash is already released, so a late abort changes nothing.
      if (abort && state != IDLE && state != DESEL) begin
        state     <= DESEL;
        spisck    <= 1'b0;
        spimosi   <= 1'b0;
        prom_cs_n <= 1'b1;
        div_cnt   <= '0;
        ab_pend   <= 1'b1;
        if (DIV1) begin
          done    <= 1'b1;
          aborted <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= SETUP;
              busy       <= 1'b1;
              prom_cs_n  <= 1'b0;
              spisck     <= 1'b0;
              spimosi    <= cmd_op[7];
              tx_sr      <= {cmd_op[6:0], addr};
              has_addr_q <= has_addr;
              data_bits  <= len_bits;
              bit_cnt    <= BW'(8);
              div_cnt    <= '0;
              rx_sr      <= '0;
              ab_pend    <= 1'b0;
            end
          end

          SETUP: begin
            if (div_last) begin
              state   <= CMD;
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end

          CMD, ADDR, DATA: begin
            if (!div_last) begin
              div_cnt <= div_cnt + 8'd1;
            end else begin
              div_cnt <= '0;
              spisck  <= ~spisck;
              if (!spisck) begin
                // Rising sck edge: capture miso; the 8th bit of a byte completes rd_data.
                if (state == DATA) begin
                  rx_sr <= {rx_sr[5:0], spimiso};
                  if (bit_cnt[2:0] == 3'd1) begin
                    rd_data  <= {rx_sr, spimiso};
                    rd_valid <= 1'b1;
                  end
                end
              end else if (bit_cnt != BW'(1)) begin
                bit_cnt <= bit_cnt - BW'(1);
                tx_sr   <= tx_sr << 1;
                spimosi <= (state == DATA) ? 1'b0 : tx_sr[TW-2];
              end else begin
                tx_sr <= tx_sr << 1;
                if (state == CMD && has_addr_q) begin
                  state   <= ADDR;
                  bit_cnt <= BW'(AW);
                  spimosi <= tx_sr[TW-2];
                end else if (state != DATA && data_bits != '0) begin
                  state   <= DATA;
                  bit_cnt <= data_bits;
                  spimosi <= 1'b0;
                end else begin
                  state   <= HOLD;
                  spimosi <= 1'b0;
                end
              end
            end
          end

          HOLD: begin
            if (div_last) begin
              state     <= DESEL;
              prom_cs_n <= 1'b1;
              div_cnt   <= '0;
              if (DIV1) begin
                done    <= 1'b1;
                aborted <= 1'b0;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end

          DESEL: begin
            if (div_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              div_cnt <= div_cnt + 8'd1;
              // done is registered, so raise it one cycle early to land on the last DESEL cycle.
              if (div_cnt + 8'd1 == DIV_LAST) begin
                done    <= 1'b1;
                aborted <= ab_pend;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Bench for spi_flash_cmd: two instances (CLK_DIV=1 and CLK_DIV=3), each talking to a small
// behavioural M25P16-style flash (RDID 20 20 15, RDSR 02, READ data = addr ^ 5A).
module tb_spi_flash_cmd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [7:0]  cmd_op = 8'h00;
  logic        has_addr = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [8:0]  rd_len = 9'd0;
  logic        start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic        miso1 = 1'b0, miso3 = 1'b0;

  logic       sck1, mosi1, cs1, rv1, busy1, done1, ab1;
  logic       sck3, mosi3, cs3, rv3, busy3, done3, ab3;
  logic [7:0] rd1, rd3;

  spi_flash_cmd #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmd_op(cmd_op), .has_addr(has_addr),
    .addr(addr), .rd_len(rd_len), .abort(abort1), .spimiso(miso1), .spisck(sck1),
    .spimosi(mosi1), .prom_cs_n(cs1), .rd_data(rd1), .rd_valid(rv1), .busy(busy1),
    .done(done1), .aborted(ab1));

  spi_flash_cmd #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cmd_op(cmd_op), .has_addr(has_addr),
    .addr(addr), .rd_len(rd_len), .abort(abort3), .spimiso(miso3), .spisck(sck3),
    .spimosi(mosi3), .prom_cs_n(cs3), .rd_data(rd3), .rd_valid(rv3), .busy(busy3),
    .done(done3), .aborted(ab3));

  function automatic logic [7:0] flash_byte(input logic [7:0] cmd, input logic [23:0] a, input int idx);
    logic [23:0] ea;
    ea = a + 24'(idx);
    case (cmd)
      8'h9F: begin
        case (idx)
          0: return 8'h20;
          1: return 8'h20;
          2: return 8'h15;
          default: return 8'h00;
        endcase
      end
      8'h05: return 8'h02;
      8'h03: return ea[7:0] ^ 8'h5A;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic flash_miso(input logic [7:0] cmd, input logic [23:0] a, input int cnt);
    int d;
    logic [7:0] b;
    if (cnt < 8) return 1'b0;
    d = (cmd == 8'h03) ? cnt - 32 : cnt - 8;
    if (d < 0) return 1'b0;
    b = flash_byte(cmd, a, d / 8);
    return b[7 - (d % 8)];
  endfunction

  // Flash models: shift in on sck rise, drive next bit on sck fall.
  int f1_cnt = 0, f3_cnt = 0;
  logic [7:0]  f1_cmd = 8'h0, f3_cmd = 8'h0;
  logic [23:0] f1_addr = 24'h0, f3_addr = 24'h0;

  always @(posedge sck1 or posedge cs1) begin
    if (cs1) f1_cnt = 0;
    else begin
      if (f1_cnt < 8) f1_cmd = {f1_cmd[6:0], mosi1};
      else if (f1_cnt < 32) f1_addr = {f1_addr[22:0], mosi1};
      f1_cnt++;
    end
  end
  always @(negedge sck1) miso1 = flash_miso(f1_cmd, f1_addr, f1_cnt);

  always @(posedge sck3 or posedge cs3) begin
    if (cs3) f3_cnt = 0;
    else begin
      if (f3_cnt < 8) f3_cmd = {f3_cmd[6:0], mosi3};
      else if (f3_cnt < 32) f3_addr = {f3_addr[22:0], mosi3};
      f3_cnt++;
    end
  end
  always @(negedge sck3) miso3 = flash_miso(f3_cmd, f3_addr, f3_cnt);

  // Monitors: sample on the falling clk edge, away from DUT updates.
  int cs_low1 = 0, rise1 = 0, nval1 = 0, ndone1 = 0;
  logic last_ab1 = 1'b0, sck1_q = 1'b0;
  logic [7:0] rx1 [1024];
  always @(negedge clk) begin
    if (!cs1) cs_low1++;
    if (sck1 && !sck1_q) rise1++;
    sck1_q = sck1;
    if (rv1) begin rx1[nval1 % 1024] = rd1; nval1++; end
    if (done1) begin ndone1++; last_ab1 = ab1; end
  end

  int cs_low3 = 0, rise3 = 0, nval3 = 0, ndone3 = 0, run3 = 0, hibad3 = 0, lobad3 = 0, rin3 = 0;
  logic last_ab3 = 1'b0, sck3_q = 1'b0, cs3_q = 1'b1;
  logic [63:0] txr3 = 64'h0, txs3 = 64'h0;
  logic [7:0] rx3 [1024];
  always @(negedge clk) begin
    if (!cs3) cs_low3++;
    if (sck3 != sck3_q) begin
      if (sck3_q && run3 != 3) hibad3++;
      if (!sck3_q && rin3 > 0 && run3 != 3) lobad3++;
      run3 = 1;
    end else run3++;
    if (sck3 && !sck3_q) begin rise3++; rin3++; txr3 = {txr3[62:0], mosi3}; end
    if (cs3 && !cs3_q) txs3 = txr3;
    if (cs3) begin rin3 = 0; txr3 = 64'h0; end
    sck3_q = sck3;
    cs3_q = cs3;
    if (rv3) begin rx3[nval3 % 1024] = rd3; nval3++; end
    if (done3) begin ndone3++; last_ab3 = ab3; end
  end

  int checks = 0, failures = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic go(input bit d3, input logic [7:0] op, input logic ha, input logic [23:0] a,
                    input logic [8:0] len, input logic ab);
    cmd_op = op; has_addr = ha; addr = a; rd_len = len;
    if (d3) begin start3 = 1'b1; abort3 = ab; end
    else begin start1 = 1'b1; abort1 = ab; end
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0; abort1 = 1'b0; abort3 = 1'b0;
  endtask

  task automatic wait_idle(input bit d3, input int limit);
    int n;
    n = 0;
    while ((d3 ? busy3 : busy1) && n < limit) begin @(negedge clk); n++; end
    chk("idle_reached", d3 ? busy3 : busy1, 0);
  endtask

  task automatic check_bytes(input bit d3, input int base, input string tag);
    int n;
    n = (d3 ? nval3 : nval1) - base;
    for (int i = 0; i < n && exp_q.size() > 0; i++)
      chk($sformatf("%s_byte%0d", tag, i), d3 ? rx3[(base + i) % 1024] : rx1[(base + i) % 1024],
          exp_q.pop_front());
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic        ha;
    logic [23:0] a;
    logic [8:0]  len;
    int          cs_low;
    int          rises;
    int          nval;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int b_cs, b_r, b_v, b_d, b_lo, b_hi, n;
    // CLK_DIV=1: cs low = 1 + 2*bits + 1
    tbl[0] = '{8'h9F, 1'b0, 24'h000000, 9'd3,   66,   32,   3};
    tbl[1] = '{8'h06, 1'b0, 24'h000000, 9'd0,   18,   8,    0};
    tbl[2] = '{8'h05, 1'b0, 24'h123456, 9'd1,   34,   16,   1};
    tbl[3] = '{8'h03, 1'b1, 24'h000100, 9'd4,   130,  64,   4};
    tbl[4] = '{8'h03, 1'b1, 24'hABCDEF, 9'd0,   66,   32,   0};
    tbl[5] = '{8'h03, 1'b1, 24'h00FFFE, 9'd300, 4162, 2080, 256};

    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs1, 1);
    chk("rst_sck", sck1, 0);
    chk("rst_mosi", mosi1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rd_valid", rv1, 0);
    chk("rst_aborted", ab1, 0);
    chk("rst_rd_data", rd1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      b_cs = cs_low1; b_r = rise1; b_v = nval1; b_d = ndone1;
      for (int i = 0; i < tbl[v].nval; i++) exp_q.push_back(flash_byte(tbl[v].op, tbl[v].a, i));
      go(1'b0, tbl[v].op, tbl[v].ha, tbl[v].a, tbl[v].len, 1'b0);
      wait_idle(1'b0, 10000);
      #1;
      chk($sformatf("v%0d_cs_low", v), cs_low1 - b_cs, tbl[v].cs_low);
      chk($sformatf("v%0d_sck_rises", v), rise1 - b_r, tbl[v].rises);
      chk($sformatf("v%0d_rd_valid", v), nval1 - b_v, tbl[v].nval);
      chk($sformatf("v%0d_done", v), ndone1 - b_d, 1);
      chk($sformatf("v%0d_aborted", v), last_ab1, 0);
      check_bytes(1'b0, b_v, $sformatf("v%0d", v));
      @(negedge clk);
    end

    // abort together with start in IDLE: start wins
    b_r = rise1; b_d = ndone1;
    go(1'b0, 8'h06, 1'b0, 24'h0, 9'd0, 1'b1);
    wait_idle(1'b0, 200);
    #1;
    chk("idle_abort_done", ndone1 - b_d, 1);
    chk("idle_abort_aborted", last_ab1, 0);
    chk("idle_abort_rises", rise1 - b_r, 8);
    @(negedge clk);

    // abort during the second RDID data byte
    b_v = nval1; b_d = ndone1;
    exp_q.push_back(8'h20);
    go(1'b0, 8'h9F, 1'b0, 24'h0, 9'd3, 1'b0);
    n = 0;
    while (nval1 == b_v && n < 200) begin @(negedge clk); n++; end
    chk("abort_first_byte_seen", nval1 - b_v, 1);
    repeat (4) @(negedge clk);
    abort1 = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cs_n", cs1, 1);
    chk("abort_sck", sck1, 0);
    chk("abort_no_rd_valid", rv1, 0);
    abort1 = 1'b0;
    wait_idle(1'b0, 200);
    #1;
    chk("abort_rd_valid_count", nval1 - b_v, 1);
    chk("abort_done", ndone1 - b_d, 1);
    chk("abort_aborted", last_ab1, 1);
    check_bytes(1'b0, b_v, "abort");
    @(negedge clk);

    // start while busy is ignored; start on the first IDLE cycle is taken
    b_r = rise1; b_v = nval1; b_d = ndone1;
    go(1'b0, 8'h06, 1'b0, 24'h0, 9'd0, 1'b0);
    repeat (3) @(negedge clk);
    go(1'b0, 8'h9F, 1'b0, 24'h0, 9'd3, 1'b0);
    wait_idle(1'b0, 200);
    go(1'b0, 8'h06, 1'b0, 24'h0, 9'd0, 1'b0);
    wait_idle(1'b0, 200);
    #1;
    chk("busy_start_done", ndone1 - b_d, 2);
    chk("busy_start_rises", rise1 - b_r, 16);
    chk("busy_start_no_data", nval1 - b_v, 0);
    chk("busy_start_aborted", last_ab1, 0);
    @(negedge clk);

    // CLK_DIV=3 READ with address
    b_cs = cs_low3; b_r = rise3; b_v = nval3; b_d = ndone3; b_lo = lobad3; b_hi = hibad3;
    for (int i = 0; i < 2; i++) exp_q.push_back(flash_byte(8'h03, 24'h000010, i));
    go(1'b1, 8'h03, 1'b1, 24'h000010, 9'd2, 1'b0);
    wait_idle(1'b1, 2000);
    #1;
    chk("div3_cs_low", cs_low3 - b_cs, 294);
    chk("div3_rises", rise3 - b_r, 48);
    chk("div3_high_len_errs", hibad3 - b_hi, 0);
    chk("div3_low_len_errs", lobad3 - b_lo, 0);
    chk("div3_mosi_bits", txs3, 64'h0000_0300_0010_0000);
    chk("div3_rd_valid", nval3 - b_v, 2);
    chk("div3_done", ndone3 - b_d, 1);
    chk("div3_aborted", last_ab3, 0);
    check_bytes(1'b1, b_v, "div3");
    @(negedge clk);

    // reset in the middle of the address phase
    b_r = rise3; b_d = ndone3;
    go(1'b1, 8'h03, 1'b1, 24'h123456, 9'd2, 1'b0);
    n = 0;
    while (rise3 - b_r < 14 && n < 500) begin @(negedge clk); n++; end
    chk("rst_mid_addr_reached", rise3 - b_r >= 14, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", cs3, 1);
    chk("rst_mid_sck", sck3, 0);
    chk("rst_mid_mosi", mosi3, 0);
    chk("rst_mid_busy", busy3, 0);
    chk("rst_mid_done", done3, 0);
    chk("rst_mid_rd_valid", rv3, 0);
    chk("rst_mid_aborted", ab3, 0);
    chk("rst_mid_rd_data", rd3, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_done", ndone3 - b_d, 0);

    // fresh RDID after reset
    b_cs = cs_low3; b_v = nval3; b_d = ndone3;
    exp_q.push_back(8'h20); exp_q.push_back(8'h20); exp_q.push_back(8'h15);
    go(1'b1, 8'h9F, 1'b0, 24'h0, 9'd3, 1'b0);
    wait_idle(1'b1, 2000);
    #1;
    chk("post_rst_cs_low", cs_low3 - b_cs, 198);
    chk("post_rst_rd_valid", nval3 - b_v, 3);
    chk("post_rst_done", ndone3 - b_d, 1);
    chk("post_rst_aborted", last_ab3, 0);
    check_bytes(1'b1, b_v, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
